// File: rtl/ls165.sv
// 74LS165 8-bit parallel-in/serial-out shift register, cycle-accurate on CLK.
// CP/nCE are sampled as data; a rising edge of g = CP | nCE clocks the register.
module ls165 #(
  parameter int WIDTH   = 8,
  parameter bit CP_SYNC = 1'b0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             nPL,
  input  logic             CP,
  input  logic             nCE,
  input  logic             DS,
  input  logic [0:WIDTH-1] D,
  output logic             Q7,
  output logic             nQ7
);

  logic [0:WIDTH-1] sr;
  logic             g;
  logic             g_prev;
  logic             shift_evt;

  generate
    if (CP_SYNC) begin : g_sync
      // Flops reset high so a chip clock already high at release is not seen as an edge.
      logic [1:0] cp_s;
      logic [1:0] nce_s;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          cp_s  <= 2'b11;
          nce_s <= 2'b11;
        end else begin
          cp_s  <= {cp_s[0], CP};
          nce_s <= {nce_s[0], nCE};
        end
      end

      assign g = cp_s[1] | nce_s[1];
    end else begin : g_direct
      assign g = CP | nCE;
    end
  endgenerate

  assign shift_evt = !g_prev && g;

  // g_prev tracks g even during a load, so an edge seen while nPL is low is consumed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sr     <= '0;
      g_prev <= 1'b1;
    end else begin
      g_prev <= g;
      if (!nPL) begin
        sr <= D;
      end else if (shift_evt) begin
        sr <= {DS, sr[0:WIDTH-2]};
      end
    end
  end

  assign Q7  = sr[WIDTH-1];
  assign nQ7 = ~sr[WIDTH-1];

endmodule
